uart_axil_slave: RTL and testbench

UART_AXIL_SLAVE -- requirements
Module: uart_axil_slave

---
 rtl/uart_axil_slave.sv | 212 +++++++++++++++++++++
 tb/tb_uart_axil_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_slave.sv
// AXI4-Lite register front end for a UART: TXDATA push, RXDATA pop, STATUS, SCRATCH.
// Latency: write completes (bvalid, write_uart) 1 cycle after AW and W are both held; read data valid 1 cycle after AR accept.
// Backpressure: bvalid/rvalid and their payloads hold until bready/rready; no new AW/W/AR is accepted meanwhile.
//
// Ports:
//   clk_100MHz, reset_n          - clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*              - AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                   - AXI4-Lite read address/data channels
//   write_uart, write_data       - Tx FIFO push pulse and byte
//   read_uart                    - Rx FIFO pop pulse
//   read_data, rx_empty, rx_full - Rx FIFO head and flags
module uart_axil_slave #(
    parameter int DBITS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic              read_uart,
    input  logic [DBITS-1:0]  read_data,
    input  logic              rx_empty,
    input  logic              rx_full
);

    localparam logic [1:0] REG_TX  = 2'd0;
    localparam logic [1:0] REG_RX  = 2'd1;
    localparam logic [1:0] REG_ST  = 2'd2;
    localparam logic [1:0] REG_SCR = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t         r_wstate, w_wnext;
    r_state_t         r_rstate, w_rnext;

    // Held low through reset and for the first edge after release so the
    // ready outputs only come up once the block is clocking out of reset.
    logic             r_ready_en;
    logic             r_aw_held, r_w_held;
    logic [1:0]       r_aw_reg;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [1:0]       r_bresp;
    logic             r_write_uart;
    logic [DBITS-1:0] r_write_data;
    logic [31:0]      r_scratch;
    logic             r_underflow;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    logic             w_do_write, w_b_done;
    logic             w_aw_hs, w_w_hs, w_ar_hs;
    logic             w_rd_is_rx, w_uf_set, w_uf_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_addr;

    // Only address bits [3:2] select a register.
    assign w_unused_addr = ^{s_awaddr, s_araddr};

    assign s_awready  = r_ready_en && (r_wstate == W_IDLE) && !r_aw_held;
    assign s_wready   = r_ready_en && (r_wstate == W_IDLE) && !r_w_held;
    assign s_arready  = r_ready_en && (r_rstate == R_IDLE);
    assign s_bvalid   = (r_wstate == W_RESP);
    assign s_rvalid   = (r_rstate == R_DATA);
    assign s_bresp    = r_bresp;
    assign s_rdata    = r_rdata;
    assign s_rresp    = r_rresp;
    assign write_uart = r_write_uart;
    assign write_data = r_write_data;

    assign w_aw_hs    = s_awvalid && s_awready;
    assign w_w_hs     = s_wvalid && s_wready;
    assign w_ar_hs    = s_arvalid && s_arready;
    assign w_rd_is_rx = (s_araddr[3:2] == REG_RX);

    // The pop happens on the accept cycle itself, so the FIFO head read
    // into r_rdata and the pop refer to the same entry.
    assign read_uart  = w_ar_hs && w_rd_is_rx && !rx_empty;
    assign w_uf_set   = w_ar_hs && w_rd_is_rx && rx_empty;
    assign w_uf_clr   = w_do_write && (r_aw_reg == REG_ST) && r_wdata[2];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate   <= W_IDLE;
            r_rstate   <= R_IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_wstate   <= w_wnext;
            r_rstate   <= w_rnext;
            r_ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_wnext    = r_wstate;
        w_do_write = 1'b0;
        w_b_done   = 1'b0;
        case (r_wstate)
            W_IDLE: if (r_aw_held && r_w_held) begin
                w_do_write = 1'b1;
                w_wnext    = W_RESP;
            end
            W_RESP: if (s_bready) begin
                w_b_done = 1'b1;
                w_wnext  = W_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rnext = R_DATA;
            R_DATA: if (s_rready) w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (s_araddr[3:2])
            REG_RX:  w_rd_mux = rx_empty ? 32'd0 : 32'(read_data);
            REG_ST:  w_rd_mux = {29'd0, r_underflow, rx_full, ~rx_empty};
            REG_SCR: w_rd_mux = r_scratch;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // AW and W are captured independently; both latches drop together once
    // the response has been taken.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_reg  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_reg  <= s_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_b_done) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_bresp      <= 2'b00;
            r_write_uart <= 1'b0;
            r_write_data <= '0;
            r_scratch    <= 32'd0;
        end else begin
            r_write_uart <= 1'b0;
            if (w_do_write) begin
                r_bresp <= (r_aw_reg == REG_RX) ? 2'b10 : 2'b00;
                if ((r_aw_reg == REG_TX) && r_wstrb[0]) begin
                    r_write_uart <= 1'b1;
                    r_write_data <= r_wdata[DBITS-1:0];
                end
                if (r_aw_reg == REG_SCR) begin
                    for (int i = 0; i < 4; i++) begin
                        if (r_wstrb[i]) r_scratch[8*i +: 8] <= r_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // A same-cycle underflow and software clear leave the flag set so an
    // error is never lost.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
            r_rdata     <= 32'd0;
            r_rresp     <= 2'b00;
        end else begin
            if (w_uf_set)      r_underflow <= 1'b1;
            else if (w_uf_clr) r_underflow <= 1'b0;
            if (w_ar_hs) begin
                r_rdata <= w_rd_mux;
                r_rresp <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_uart_axil_slave.sv
module tb_uart_axil_slave;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic [3:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        write_uart;
    logic [7:0]  write_data;
    logic        read_uart;
    logic [7:0]  read_data;
    logic        rx_empty;
    logic        rx_full;

    int          checks = 0;
    int          errors = 0;
    int          wu_cnt = 0;
    int          ru_cnt = 0;
    logic [7:0]  last_wd = 8'h00;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_axil_slave #(.DBITS(8), .ADDR_W(4)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .write_uart (write_uart),
        .write_data (write_data),
        .read_uart  (read_uart),
        .read_data  (read_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full)
    );

    // FIFO pulse monitor, sampled mid-cycle.
    always @(negedge clk_100MHz) begin
        if (write_uart) begin
            wu_cnt++;
            last_wd = write_data;
        end
        if (read_uart) ru_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit   a_ok;
        bit   w_ok;
        bit   b_ok;
        logic a_r;
        logic w_r;
        a_ok = 0; w_ok = 0; b_ok = 0; resp = 2'b11;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int n = 0; n < 20 && !(a_ok && w_ok); n++) begin
            @(negedge clk_100MHz);
            a_r = s_awready;
            w_r = s_wready;
            tick();
            if (a_r && !a_ok) begin a_ok = 1; s_awvalid = 1'b0; end
            if (w_r && !w_ok) begin w_ok = 1; s_wvalid = 1'b0; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        for (int n = 0; n < 20 && !b_ok; n++) begin
            @(negedge clk_100MHz);
            if (s_bvalid) begin b_ok = 1; resp = s_bresp; end
            tick();
        end
        s_bready = 1'b0;
        check("wr_complete", 32'(a_ok && w_ok && b_ok), 1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit   a_ok;
        bit   r_ok;
        logic a_r;
        a_ok = 0; r_ok = 0; data = 32'hFFFF_FFFF; resp = 2'b11;
        s_araddr = addr; s_arvalid = 1'b1;
        for (int n = 0; n < 20 && !a_ok; n++) begin
            @(negedge clk_100MHz);
            a_r = s_arready;
            tick();
            if (a_r) begin a_ok = 1; s_arvalid = 1'b0; end
        end
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        for (int n = 0; n < 20 && !r_ok; n++) begin
            @(negedge clk_100MHz);
            if (s_rvalid) begin r_ok = 1; data = s_rdata; resp = s_rresp; end
            tick();
        end
        s_rready = 1'b0;
        check("rd_complete", 32'(a_ok && r_ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [1:0]  resp2;
        logic [31:0] rd;
        int          wu0;
        int          ru0;

        reset_n = 1'b0;
        s_awaddr = 4'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = 4'h0; s_arvalid = 1'b0; s_rready = 1'b0;
        read_data = 8'h00; rx_empty = 1'b1; rx_full = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(s_awready), 0);
        check("rst_wready", 32'(s_wready), 0);
        check("rst_arready", 32'(s_arready), 0);
        check("rst_bvalid", 32'(s_bvalid), 0);
        check("rst_rvalid", 32'(s_rvalid), 0);
        check("rst_fifo_pulses", 32'({write_uart, read_uart}), 0);
        check("rst_write_data", 32'(write_data), 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_resps", 32'({s_bresp, s_rresp}), 0);

        // Readies rise on the first edge after release
        reset_n = 1'b1;
        @(negedge clk_100MHz);
        check("awready_before_edge", 32'(s_awready), 0);
        tick();
        check("ready_after_edge", 32'({s_awready, s_wready, s_arready}), 32'h7);

        // Simultaneous AW/W to TXDATA
        wu0 = wu_cnt;
        axi_write(4'h0, 32'h0000_00A5, 4'hF, resp);
        tick();
        check("tx_a5_bresp", 32'(resp), 0);
        check("tx_a5_pushes", wu_cnt - wu0, 1);
        check("tx_a5_data", 32'(last_wd), 32'hA5);

        // TXDATA with wstrb[0]=0: no push, still OKAY
        wu0 = wu_cnt;
        axi_write(4'h0, 32'h0000_0011, 4'hE, resp);
        tick();
        check("tx_nostrb_bresp", 32'(resp), 0);
        check("tx_nostrb_pushes", wu_cnt - wu0, 0);

        // W three cycles ahead of AW; response back-pressured for 4 cycles
        wu0 = wu_cnt;
        s_wdata = 32'h0000_003C; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        tick(); tick();
        check("w_first_no_push", wu_cnt - wu0, 0);
        check("w_first_wready_low", 32'(s_wready), 0);
        check("w_first_awready_high", 32'(s_awready), 1);
        check("w_first_no_bvalid", 32'(s_bvalid), 0);
        s_awaddr = 4'h0; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bvalid_held", 32'(s_bvalid), 1);
            check("bresp_held", 32'(s_bresp), 0);
            tick();
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("bvalid_dropped", 32'(s_bvalid), 0);
        check("w_first_pushes", wu_cnt - wu0, 1);
        check("w_first_data", 32'(last_wd), 32'h3C);
        check("w_first_ready_back", 32'({s_awready, s_wready}), 32'h3);

        // RXDATA reads: non-empty pops, empty flags underflow
        rx_empty = 1'b0; read_data = 8'h5A;
        ru0 = ru_cnt;
        axi_read(4'h4, rd, resp);
        check("rx_5a_rdata", rd, 32'h0000_005A);
        check("rx_5a_rresp", 32'(resp), 0);
        check("rx_5a_pops", ru_cnt - ru0, 1);
        rx_empty = 1'b1;
        ru0 = ru_cnt;
        axi_read(4'h4, rd, resp);
        check("rx_empty_rdata", rd, 0);
        check("rx_empty_rresp", 32'(resp), 0);
        check("rx_empty_pops", ru_cnt - ru0, 0);
        axi_read(4'h8, rd, resp);
        check("status_underflow", rd, 32'h4);

        // STATUS clear and SCRATCH byte lanes
        axi_write(4'h8, 32'h0000_0004, 4'hF, resp);
        check("status_clr_bresp", 32'(resp), 0);
        axi_read(4'h8, rd, resp);
        check("status_cleared", rd, 0);
        rx_full = 1'b1;
        axi_read(4'h8, rd, resp);
        check("status_rx_full", rd, 32'h2);
        rx_full = 1'b0;
        axi_write(4'hC, 32'hDEAD_BEEF, 4'h3, resp);
        check("scratch_bresp", 32'(resp), 0);
        axi_read(4'hC, rd, resp);
        check("scratch_lanes", rd, 32'h0000_BEEF);

        // Same-edge STATUS clear and underflow set: flag stays set
        ru0 = ru_cnt;
        s_awaddr = 4'h8; s_wdata = 32'h0000_0004; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 4'h4; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("race_rvalid", 32'(s_rvalid), 1);
        check("race_bvalid", 32'(s_bvalid), 1);
        check("race_rdata", s_rdata, 0);
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        check("race_both_done", 32'({s_bvalid, s_rvalid}), 0);
        axi_read(4'h8, rd, resp);
        check("race_set_wins", rd, 32'h4);
        check("race_no_pop", ru_cnt - ru0, 0);

        // Write to RXDATA: SLVERR and no FIFO activity
        wu0 = wu_cnt; ru0 = ru_cnt;
        axi_write(4'h4, 32'h0000_00FF, 4'hF, resp);
        tick();
        check("rx_write_bresp", 32'(resp), 32'h2);
        check("rx_write_no_pulses", (wu_cnt - wu0) + (ru_cnt - ru0), 0);

        // Concurrent read of SCRATCH and write of TXDATA
        wu0 = wu_cnt;
        fork
            axi_read(4'hC, rd, resp2);
            axi_write(4'h0, 32'h0000_0077, 4'hF, resp);
        join
        tick();
        check("conc_rdata", rd, 32'h0000_BEEF);
        check("conc_rresp", 32'(resp2), 0);
        check("conc_bresp", 32'(resp), 0);
        check("conc_pushes", wu_cnt - wu0, 1);
        check("conc_data", 32'(last_wd), 32'h77);

        // Reset during R_DATA
        s_araddr = 4'hC; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("pre_rst_rvalid", 32'(s_rvalid), 1);
        wu0 = wu_cnt; ru0 = ru_cnt;
        reset_n = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(s_rvalid), 0);
        check("async_rst_arready", 32'(s_arready), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_arready", 32'(s_arready), 1);
        tick(); tick();
        check("post_rst_no_pulses", (wu_cnt - wu0) + (ru_cnt - ru0), 0);
        axi_read(4'hC, rd, resp);
        check("post_rst_scratch", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
